multicycle_core: RTL and testbench

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_core.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core sharing one memory port between instruction fetch and data.
// Optional macro TRIGGER_GATE_EN: IDLE waits for TRIGGER=1 before the first fetch.
module multicycle_core #(
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned RESET_PC       = 0,
    parameter int          MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      TRIGGER,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     a0,
    output logic                      halted
);
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEMADDR, MEMREAD, MEMWRITE, MEMWB, ALUWB, HALT
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] pc, old_pc, rs1v, rs2v, imm, alu_out, mdr;
    logic [DATA_WIDTH-1:0] imm_dec, alu_b, alu_res, rf_wd, addr_src, jalr_sum;
    logic [DATA_WIDTH-1:0] regs [0:31];
    logic [31:0]           ir;
    logic                  rf_we, taken;
    logic [6:0]            opcode;
    logic [4:0]            rd, rs1, rs2, shamt;
    logic [2:0]            f3;
    logic                  alt;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign alt    = ir[30];

    assign a0        = regs[10];
    assign halted    = (state == HALT);
    assign mem_wdata = rs2v;
    assign addr_src  = (state == FETCH) ? pc : alu_out;
    assign mem_addr  = addr_src[MEM_ADDR_WIDTH-1:0] & ~MEM_ADDR_WIDTH'(3);
    assign taken     = (f3 == 3'd0) ? (rs1v == rs2v) : (rs1v != rs2v);
    assign jalr_sum  = rs1v + imm;

`ifndef TRIGGER_GATE_EN
    logic unused_trigger;
    assign unused_trigger = TRIGGER;
`endif

    always_comb begin
        case (opcode)
            OP_STORE:  imm_dec = DATA_WIDTH'($signed({ir[31:25], ir[11:7]}));
            OP_BRANCH: imm_dec = DATA_WIDTH'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
            OP_JAL:    imm_dec = DATA_WIDTH'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
            OP_LUI:    imm_dec = DATA_WIDTH'($signed({ir[31:12], 12'h000}));
            default:   imm_dec = DATA_WIDTH'($signed(ir[31:20]));
        endcase
    end

    // R-type uses rs2; I-type uses the immediate, whose bit 10 selects srai like funct7 does
    always_comb begin
        alu_b = (opcode == OP_REG) ? rs2v : imm;
        shamt = alu_b[4:0];
        case (f3)
            3'd0:    alu_res = (opcode == OP_REG && alt) ? rs1v - alu_b : rs1v + alu_b;
            3'd1:    alu_res = rs1v << shamt;
            3'd2:    alu_res = DATA_WIDTH'($signed(rs1v) < $signed(alu_b));
            3'd3:    alu_res = DATA_WIDTH'(rs1v < alu_b);
            3'd4:    alu_res = rs1v ^ alu_b;
            3'd5:    alu_res = alt ? DATA_WIDTH'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'd6:    alu_res = rs1v | alu_b;
            default: alu_res = rs1v & alu_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
`ifdef TRIGGER_GATE_EN
            IDLE:     state_nxt = TRIGGER ? FETCH : IDLE;
`else
            IDLE:     state_nxt = FETCH;
`endif
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_REG, OP_IMM, OP_JAL, OP_JALR, OP_LUI: state_nxt = EXECUTE;
                    OP_LOAD, OP_STORE: state_nxt = (f3 == 3'd2) ? MEMADDR : HALT;
                    OP_BRANCH: state_nxt = (f3 == 3'd0 || f3 == 3'd1) ? EXECUTE : HALT;
                    default:   state_nxt = HALT;
                endcase
            end
            EXECUTE:  state_nxt = (opcode == OP_REG || opcode == OP_IMM) ? ALUWB : FETCH;
            MEMADDR:  state_nxt = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                mem_req = 1'b1;
                if (mem_ready) state_nxt = MEMWB;
            end
            MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) state_nxt = FETCH;
            end
            MEMWB, ALUWB: state_nxt = FETCH;
            HALT:     state_nxt = HALT;
            default:  state_nxt = IDLE;
        endcase
    end

    // Single register-file write port: jal/jalr/lui in EXECUTE, loads in MEMWB, ALU ops in ALUWB
    always_comb begin
        rf_we = 1'b0;
        rf_wd = alu_out;
        case (state)
            EXECUTE: begin
                rf_we = (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_LUI);
                rf_wd = (opcode == OP_LUI) ? imm : old_pc + DATA_WIDTH'(4);
            end
            MEMWB: begin
                rf_we = 1'b1;
                rf_wd = mdr;
            end
            ALUWB:   rf_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rd != 5'd0) begin
            regs[rd] <= rf_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= DATA_WIDTH'(RESET_PC);
            old_pc  <= '0;
            ir      <= '0;
            rs1v    <= '0;
            rs2v    <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                FETCH: if (mem_ready) begin
                    ir     <= mem_rdata[31:0];
                    old_pc <= pc;
                    pc     <= pc + DATA_WIDTH'(4);
                end
                DECODE: begin
                    rs1v <= regs[rs1];
                    rs2v <= regs[rs2];
                    imm  <= imm_dec;
                end
                EXECUTE: begin
                    case (opcode)
                        OP_REG, OP_IMM: alu_out <= alu_res;
                        OP_BRANCH:      if (taken) pc <= old_pc + imm;
                        OP_JAL:         pc <= old_pc + imm;
                        OP_JALR:        pc <= {jalr_sum[DATA_WIDTH-1:1], 1'b0};
                        default: ;
                    endcase
                end
                MEMADDR: alu_out <= rs1v + imm;
                MEMREAD: if (mem_ready) mdr <= mem_rdata;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: instruction-level reference model predicts every memory
// transaction into a queue; a negedge memory/monitor process pops and compares.
module tb_multicycle_core;
    localparam int          DW  = 32;
    localparam int unsigned RPC = 32'h100;

    logic          clk = 1'b0, rst = 1'b0, TRIGGER = 1'b0, mem_ready = 1'b0;
    logic          mem_req, mem_we, halted;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata, a0;

    multicycle_core #(.DATA_WIDTH(DW), .RESET_PC(RPC), .MEM_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .TRIGGER(TRIGGER), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .a0(a0), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;

    logic [31:0] mem  [1024];
    logic [31:0] rmem [1024];
    logic [31:0] prog [$];
    logic [31:0] rd_log [$];
    txn_t        exp_q [$];
    txn_t        mon_e;
    logic [31:0] ref_a0;
    int          tests = 0, fails = 0;
    int          fixed_wait = 0;   // -1 selects random wait states
    int          wait_max = 2;
    int          wait_cnt = 0;
    bit          in_txn = 0;

    assign mem_rdata = mem[mem_addr[11:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Memory model with wait states; a transaction is checked when ready is raised
    always @(negedge clk) begin
        if (mem_ready) in_txn = 0;
        if (!mem_req) begin
            in_txn    = 0;
            mem_ready = 1'b0;
        end else begin
            if (!in_txn) begin
                in_txn   = 1;
                wait_cnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, wait_max));
            end
            if (wait_cnt > 0) begin
                mem_ready = 1'b0;
                wait_cnt--;
            end else begin
                mem_ready = 1'b1;
                if (!mem_we) rd_log.push_back(mem_addr);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL txn_unexpected: got addr %h we %b, expected no request", mem_addr, mem_we);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("txn_addr", mem_addr, mon_e.addr);
                    check("txn_we", {31'b0, mem_we}, {31'b0, mon_e.we});
                    if (mon_e.we) check("txn_wdata", mem_wdata, mon_e.data);
                end
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            end
        end
    end

    function automatic logic [31:0] e_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] e_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] e_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] ref_alu(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Instruction-set reference: executes rmem from RPC and lists the expected bus traffic
    task automatic iss_run();
        logic [31:0] x [32];
        logic [31:0] pc, ins, a, b, r, npc, ad, immi, imms, immb, immj;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        bit          wr, stop;
        foreach (x[i]) x[i] = 32'h0;
        pc   = RPC;
        stop = 0;
        exp_q.delete();
        for (int n = 0; n < 4000 && !stop; n++) begin
            exp_q.push_back('{we: 1'b0, addr: pc, data: 32'h0});
            ins  = rmem[pc[11:2]];
            op   = ins[6:0];
            rd   = ins[11:7];
            f3   = ins[14:12];
            a    = x[ins[19:15]];
            b    = x[ins[24:20]];
            immi = {{20{ins[31]}}, ins[31:20]};
            imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            immb = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            immj = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            npc  = pc + 32'd4;
            wr   = 0;
            r    = 32'h0;
            case (op)
                7'h33: begin r = ref_alu(f3, ins[30], a, b); wr = 1; end
                7'h13: begin r = ref_alu(f3, (f3 == 3'd5) && ins[30], a, immi); wr = 1; end
                7'h03: if (f3 != 3'd2) stop = 1;
                       else begin
                           ad = (a + immi) & ~32'h3;
                           exp_q.push_back('{we: 1'b0, addr: ad, data: 32'h0});
                           r  = rmem[ad[11:2]];
                           wr = 1;
                       end
                7'h23: if (f3 != 3'd2) stop = 1;
                       else begin
                           ad = (a + imms) & ~32'h3;
                           exp_q.push_back('{we: 1'b1, addr: ad, data: b});
                           rmem[ad[11:2]] = b;
                       end
                7'h63: if (f3 == 3'd0) begin if (a == b) npc = pc + immb; end
                       else if (f3 == 3'd1) begin if (a != b) npc = pc + immb; end
                       else stop = 1;
                7'h6F: begin r = pc + 32'd4; wr = 1; npc = pc + immj; end
                7'h67: begin r = pc + 32'd4; wr = 1; npc = (a + immi) & ~32'h1; end
                7'h37: begin r = {ins[31:12], 12'h000}; wr = 1; end
                default: stop = 1;
            endcase
            if (wr && rd != 5'd0) x[rd] = r;
            pc = npc;
        end
        ref_a0 = x[10];
    endtask

    task automatic gen_random(input int n);
        logic [31:0] ins;
        logic [11:0] imm, dad;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        int          tgt;
        prog.delete();
        for (int i = 0; i < n; i++) begin
            rd  = 5'($urandom_range(1, 15));
            r1  = 5'($urandom_range(0, 15));
            r2  = 5'($urandom_range(0, 15));
            f3  = 3'($urandom);
            dad = 12'(32'h400 + 4 * $urandom_range(0, 63));
            tgt = i + int'($urandom_range(1, 3));
            if (tgt > n) tgt = n;
            case ($urandom_range(0, 8))
                0, 1: ins = e_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r2, r1, f3, rd);
                2, 3: begin
                    if (f3 == 3'd1)      imm = {7'h00, 5'($urandom)};
                    else if (f3 == 3'd5) imm = {1'b0, 1'($urandom), 5'h00, 5'($urandom)};
                    else                 imm = 12'($urandom);
                    ins = e_i(imm, r1, f3, rd, 7'h13);
                end
                4: ins = {20'($urandom), rd, 7'h37};
                5: ins = e_i(dad, 5'd0, 3'd2, rd, 7'h03);
                6: ins = e_s(dad, r2, 5'd0);
                7: ins = e_b(13'((tgt - i) * 4), r2, r1, {2'b00, f3[0]});
                default: ins = ($urandom_range(0, 1) == 1) ? e_j(21'((tgt - i) * 4), rd)
                                                          : e_i(12'(RPC + 4 * tgt), 5'd0, 3'd0, rd, 7'h67);
            endcase
            prog.push_back(ins);
        end
        for (int r = 1; r < 16; r++) prog.push_back(e_s(12'(32'h600 + 4 * r), 5'(r), 5'd0));
        prog.push_back(32'h0000_007F);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        TRIGGER = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_a0", a0, 32'h0);
        rst = 1'b1;
`ifdef TRIGGER_GATE_EN
        repeat (10) begin
            @(negedge clk);
            check("gate_no_req", {31'b0, mem_req}, 32'h0);
        end
        TRIGGER = 1'b1;
`endif
    endtask

    task automatic start_prog();
        foreach (mem[i]) mem[i] = $urandom;
        for (int i = 0; i < prog.size(); i++) mem[(RPC >> 2) + i] = prog[i];
        foreach (rmem[i]) rmem[i] = mem[i];
        rd_log.delete();
        iss_run();
        do_reset();
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_halted"}, {31'b0, halted}, 32'h1);
        check({name, "_pending"}, 32'(exp_q.size()), 32'h0);
        check({name, "_a0"}, a0, ref_a0);
        repeat (3) begin
            @(negedge clk);
            check({name, "_halt_no_req"}, {31'b0, mem_req}, 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // addi x10,x0,5 at zero wait: a0 appears on the 5th edge after start
        fixed_wait = 0;
        prog.delete();
        prog.push_back(e_i(12'd5, 5'd0, 3'd0, 5'd10, 7'h13));
        prog.push_back(32'h0000_007F);
        start_prog();
        repeat (4) @(negedge clk);
        check("t0_a0_edge4", a0, 32'h0);
        @(negedge clk);
        check("t0_a0_edge5", a0, 32'd5);
        wait_halt("t0");

        // three fetch wait states push the result out by three cycles
        fixed_wait = 3;
        prog.delete();
        prog.push_back(e_i(12'd7, 5'd0, 3'd0, 5'd10, 7'h13));
        prog.push_back(32'h0000_007F);
        start_prog();
        repeat (3) begin
            @(negedge clk);
            check("t1_wait_addr", mem_addr, RPC);
            check("t1_wait_req", {31'b0, mem_req}, 32'h1);
        end
        repeat (4) @(negedge clk);
        check("t1_a0_edge7", a0, 32'h0);
        @(negedge clk);
        check("t1_a0_edge8", a0, 32'd7);
        wait_halt("t1");

        // store then load back through the same port
        fixed_wait = 0;
        prog.delete();
        prog.push_back(e_i(12'd5, 5'd0, 3'd0, 5'd10, 7'h13));
        prog.push_back(e_s(12'd8, 5'd10, 5'd0));
        prog.push_back(e_i(12'd8, 5'd0, 3'd2, 5'd11, 7'h03));
        prog.push_back(e_s(12'd12, 5'd11, 5'd0));
        prog.push_back(32'h0000_007F);
        start_prog();
        wait_halt("t2");
        check("t2_mem8", mem[2], 32'd5);
        check("t2_mem12", mem[3], 32'd5);

        // beq taken backwards, bne not taken
        prog.delete();
        prog.push_back(e_j(21'd8, 5'd0));
        prog.push_back(e_j(21'd12, 5'd0));
        prog.push_back(e_b(13'h1FFC, 5'd0, 5'd0, 3'd0));
        prog.push_back(32'h0000_007F);
        prog.push_back(e_b(13'h1FFC, 5'd0, 5'd0, 3'd1));
        prog.push_back(e_i(12'd3, 5'd0, 3'd0, 5'd10, 7'h13));
        prog.push_back(32'h0000_007F);
        start_prog();
        wait_halt("t3");
        check("t3_nfetch", 32'(rd_log.size()), 32'd6);
        if (rd_log.size() == 6) begin
            check("t3_fetch1", rd_log[1], RPC + 32'h8);
            check("t3_fetch2_beq", rd_log[2], RPC + 32'h4);
            check("t3_fetch4_bne", rd_log[4], RPC + 32'h14);
        end

        // load with funct3 != 010 halts from DECODE
        fixed_wait = -1;
        prog.delete();
        prog.push_back(e_i(12'd1, 5'd0, 3'd0, 5'd10, 7'h13));
        prog.push_back(e_i(12'h400, 5'd0, 3'd0, 5'd12, 7'h03));
        prog.push_back(e_i(12'd9, 5'd0, 3'd0, 5'd10, 7'h13));
        start_prog();
        wait_halt("t4");

        // reset during a stalled fetch drops the request at once
        fixed_wait = 6;
        prog.delete();
        prog.push_back(e_i(12'd5, 5'd0, 3'd0, 5'd10, 7'h13));
        prog.push_back(32'h0000_007F);
        start_prog();
        @(negedge clk);
        check("t5_req_before", {31'b0, mem_req}, 32'h1);
        #1 rst = 1'b0;
        #1 check("t5_req_async_drop", {31'b0, mem_req}, 32'h0);
        check("t5_halted", {31'b0, halted}, 32'h0);
        exp_q.delete();

        for (int t = 0; t < 8; t++) begin
            fixed_wait = (t % 2 == 1) ? -1 : 0;
            gen_random(24);
            start_prog();
            wait_halt("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
